// File: rtl/seqdiv_pkg.sv
// rtl/seqdiv_pkg.sv - shared types, default widths and counter sizing for the sequential divider
package seqdiv_pkg;

  localparam int DW_DEF = 16;
  localparam int VW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/seqdiv_step.sv
// rtl/seqdiv_step.sv - one combinational restoring-division step (shift, compare, conditional subtract)
module seqdiv_step #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic [VW:0]   r,
  input  logic [DW-1:0] q,
  input  logic [VW-1:0] d,
  output logic [VW:0]   r_next,
  output logic [DW-1:0] q_next
);

  logic [VW:0] t;
  logic        ge;
  // r stays below d, so its top bit never carries information into the next step
  logic        unused_r_msb;

  assign unused_r_msb = r[VW];
  assign t      = {r[VW-1:0], q[DW-1]};
  assign ge     = (t >= {1'b0, d});
  assign r_next = ge ? (t - {1'b0, d}) : t;
  assign q_next = {q[DW-2:0], ge};

endmodule

// File: rtl/seqdivider.sv
// rtl/seqdivider.sv - sequential restoring divider, one quotient bit per clock, load/out_valid handshake
module seqdivider
  import seqdiv_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] i_dividend,
  input  logic [VW-1:0] i_divisor,
  input  logic          load,
  output logic          busy,
  output logic          out_valid,
  output logic [DW-1:0] out_quot,
  output logic [VW-1:0] out_rem,
  output logic          out_div_by_zero
);

  localparam int            CW   = clog2(DW);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  state_e        state;
  logic [DW-1:0] q_reg;
  logic [VW-1:0] d_reg;
  logic [VW:0]   r_reg;
  logic [CW-1:0] cnt;
  logic          zero_pend;
  logic [VW:0]   r_next;
  logic [DW-1:0] q_next;

  seqdiv_step #(.DW(DW), .VW(VW)) u_step (
    .r      (r_reg),
    .q      (q_reg),
    .d      (d_reg),
    .r_next (r_next),
    .q_next (q_next)
  );

  assign busy = (state == RUN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      q_reg           <= '0;
      d_reg           <= '0;
      r_reg           <= '0;
      cnt             <= '0;
      zero_pend       <= 1'b0;
      out_valid       <= 1'b0;
      out_quot        <= '0;
      out_rem         <= '0;
      out_div_by_zero <= 1'b0;
    end else if (zero_pend) begin
      // zero divisor: the captured dividend's low bits become the remainder
      zero_pend       <= 1'b0;
      state           <= DONE;
      out_quot        <= '1;
      out_rem         <= q_reg[VW-1:0];
      out_div_by_zero <= 1'b1;
      out_valid       <= 1'b1;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (load) begin
            q_reg           <= i_dividend;
            d_reg           <= i_divisor;
            r_reg           <= '0;
            cnt             <= '0;
            out_valid       <= 1'b0;
            out_div_by_zero <= 1'b0;
            if (i_divisor == '0) begin
              zero_pend <= 1'b1;
              state     <= IDLE;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          r_reg <= r_next;
          q_reg <= q_next;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            state     <= DONE;
            out_quot  <= q_next;
            out_rem   <= r_next[VW-1:0];
            out_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seqdivider.sv
// tb/tb_seqdivider.sv - table-driven and scoreboard bench for seqdivider
module tb_seqdivider;

  typedef struct {
    logic [15:0] dd;
    logic [7:0]  dv;
    logic [15:0] q;
    logic [7:0]  r;
    logic        z;
  } vec_t;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        z;
    int          lat;
    int          bsy;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] i_dividend;
  logic [7:0]  i_divisor;
  logic        load;
  logic        busy;
  logic        out_valid;
  logic [15:0] out_quot;
  logic [7:0]  out_rem;
  logic        out_div_by_zero;

  int   n_cmp;
  int   n_bad;
  exp_t sb[$];
  vec_t tbl[10];

  seqdivider dut (
    .clk             (clk),
    .reset           (rst_n),
    .i_dividend      (i_dividend),
    .i_divisor       (i_divisor),
    .load            (load),
    .busy            (busy),
    .out_valid       (out_valid),
    .out_quot        (out_quot),
    .out_rem         (out_rem),
    .out_div_by_zero (out_div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic exp_t mk_exp(input logic [15:0] q, input logic [7:0] r, input logic z);
    exp_t e;
    e.q   = q;
    e.r   = r;
    e.z   = z;
    e.lat = z ? 1 : 16;
    e.bsy = z ? 0 : 16;
    return e;
  endfunction

  // Called at a negedge; drives load for one edge, waits for out_valid, then checks the scoreboard head.
  task automatic run_op(input string nm, input logic [15:0] dd, input logic [7:0] dv,
                        input exp_t e, input int glitch_at);
    int   lat;
    int   bc;
    exp_t x;
    i_dividend = dd;
    i_divisor  = dv;
    load       = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    load = 1'b0;
    lat  = 0;
    bc   = busy ? 1 : 0;
    chk({nm, "_valid_drop"}, out_valid, 0);
    while (!out_valid && lat < 40) begin
      if (lat == glitch_at) begin
        i_dividend = 16'd50;
        i_divisor  = 8'd5;
        load       = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
      lat++;
      if (busy) bc++;
    end
    load = 1'b0;
    chk({nm, "_timeout"}, out_valid, 1);
    x = sb.pop_front();
    chk({nm, "_quot"}, out_quot, x.q);
    chk({nm, "_rem"}, out_rem, x.r);
    chk({nm, "_dbz"}, out_div_by_zero, x.z);
    chk({nm, "_lat"}, lat, x.lat);
    chk({nm, "_busy"}, bc, x.bsy);
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    rst_n      = 1'b0;
    i_dividend = '0;
    i_divisor  = '0;
    load       = 1'b0;

    tbl[0] = '{16'd1000,  8'd7,   16'd142,   8'd6,   1'b0};
    tbl[1] = '{16'hFFFF,  8'hFF,  16'd257,   8'd0,   1'b0};
    tbl[2] = '{16'd3,     8'd10,  16'd0,     8'd3,   1'b0};
    tbl[3] = '{16'd5,     8'd0,   16'hFFFF,  8'd5,   1'b1};
    tbl[4] = '{16'd65535, 8'd1,   16'd65535, 8'd0,   1'b0};
    tbl[5] = '{16'd0,     8'd9,   16'd0,     8'd0,   1'b0};
    tbl[6] = '{16'd255,   8'd255, 16'd1,     8'd0,   1'b0};
    tbl[7] = '{16'hABCD,  8'd0,   16'hFFFF,  8'hCD,  1'b1};
    tbl[8] = '{16'd12345, 8'd128, 16'd96,    8'd57,  1'b0};
    tbl[9] = '{16'd65535, 8'd2,   16'd32767, 8'd1,   1'b0};

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_quot", out_quot, 0);
    chk("rst_rem", out_rem, 0);
    chk("rst_dbz", out_div_by_zero, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++)
      run_op($sformatf("tbl%0d", i), tbl[i].dd, tbl[i].dv, mk_exp(tbl[i].q, tbl[i].r, tbl[i].z), -1);

    // load during RUN must be ignored; then a back-to-back load in the first DONE cycle
    run_op("glitch", 16'd1000, 8'd7, mk_exp(16'd142, 8'd6, 1'b0), 8);
    run_op("b2b", 16'd50, 8'd5, mk_exp(16'd10, 8'd0, 1'b0), -1);
    @(negedge clk);
    chk("hold_valid", out_valid, 1);
    chk("hold_quot", out_quot, 10);

    // asynchronous reset in the middle of RUN
    i_dividend = 16'd1000;
    i_divisor  = 8'd7;
    load       = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_quot", out_quot, 0);
    chk("arst_rem", out_rem, 0);
    chk("arst_dbz", out_div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);
    run_op("after_rst", 16'd200, 8'd3, mk_exp(16'd66, 8'd2, 1'b0), -1);

    // multiplier-product regression: dividend = a*b, divisor = a
    for (int k = 0; k < 2000; k++) begin
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] p;
      a = 8'($urandom_range(1, 255));
      b = 8'($urandom_range(0, 255));
      p = 16'(a) * 16'(b);
      run_op("rand", p, a, mk_exp({8'd0, b}, 8'd0, 1'b0), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
